// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and bit-period helper.
// Used by uart_tx and its baud generator, and shared with uart_rx.
package uart_pkg;

    localparam int DATA_BITS = 8;

    // PARITY is only reachable when UART_TX_PARITY_EN is defined, hence 3 bits.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_e;

    function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_tick marks the last clk cycle of every serial bit.
// The count is held at zero while en is low so each frame starts on a fresh period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int clock_freq = 10000000,
    parameter int baud_rate  = 9600
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_tick
);

    localparam int CLKS_PER_BIT = clks_per_bit(clock_freq, baud_rate);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_tick = en && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (!en || bit_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, all outputs registered.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int clock_freq = 10000000,
    parameter int baud_rate  = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(clock_freq, baud_rate);
    localparam int BIT_CNT_W    = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : gen_cfg_check
        $error("uart_tx: clock_freq/baud_rate must give at least 2 clocks per bit");
    end

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shiftReg_q;
    logic [BIT_CNT_W-1:0] bitCount_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 bitTick;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    uart_baud_gen #(
        .clock_freq(clock_freq),
        .baud_rate (baud_rate)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q != IDLE),
        .bit_tick(bitTick)
    );

    // tx always carries the shifter LSB during DATA, so the next bit is shiftReg_q[1].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            bitCount_q <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_start) begin
                        state_q    <= START;
                        shiftReg_q <= tx_data;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_q   <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (bitTick) begin
                        state_q    <= DATA;
                        bitCount_q <= '0;
                        tx_q       <= shiftReg_q[0];
                    end
                end
                DATA: begin
                    if (bitTick) begin
                        shiftReg_q <= {1'b0, shiftReg_q[DATA_BITS-1:1]};
                        bitCount_q <= bitCount_q + 1'b1;
                        if (bitCount_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            tx_q <= shiftReg_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bitTick) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bitTick) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit; expected frames are built from the sent byte.
// Picks up the parity bit automatically when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int vecCount = 0;
    int errCount = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .clock_freq(1000000),
        .baud_rate (100000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Called on a negedge; returns on the negedge just after the accepting edge.
    task automatic applyStimulus(input logic [7:0] data);
        tx_start = 1'b1;
        tx_data  = data;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " tx"},   32'(tx),      32'd1);
        checkOutput({tag, " busy"}, 32'(tx_busy), 32'd0);
        checkOutput({tag, " done"}, 32'(tx_done), 32'd0);
    endtask

    // Checks the first and last cycle of every bit, then the tx_done cycle.
    // pokeIdx >= 0 pulses tx_start with pokeData at that cycle of the frame.
    task automatic checkFrame(input string tag, input logic [7:0] data,
                              input int pokeIdx, input logic [7:0] pokeData);
        logic expBits [11];
        expBits[0] = 1'b0;
        for (int i = 0; i < 8; i++) expBits[i+1] = data[i];
        expBits[9]  = ^data;
        expBits[10] = 1'b1;
        expBits[NBITS-1] = 1'b1;
        for (int idx = 0; idx < NBITS*CPB; idx++) begin
            if ((idx % CPB == 0) || (idx % CPB == CPB-1)) begin
                checkOutput($sformatf("%s tx b%0d c%0d", tag, idx/CPB, idx%CPB),
                            32'(tx), 32'(expBits[idx/CPB]));
                checkOutput($sformatf("%s busy c%0d", tag, idx), 32'(tx_busy), 32'd1);
                checkOutput($sformatf("%s done c%0d", tag, idx), 32'(tx_done), 32'd0);
            end
            tx_start = (idx == pokeIdx);
            if (idx == pokeIdx) tx_data = pokeData;
            @(negedge clk);
        end
        tx_start = 1'b0;
        checkOutput({tag, " done pulse"}, 32'(tx_done), 32'd1);
        checkOutput({tag, " busy end"},   32'(tx_busy), 32'd0);
        checkOutput({tag, " tx end"},     32'(tx),      32'd1);
    endtask

    initial begin
        $display("[TB] uart_tx bench, %0d bits per frame", NBITS);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdle("reset");
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i % 5 == 4) checkIdle($sformatf("idle hold %0d", i));
        end

        applyStimulus(8'hA5);
        checkFrame("a5", 8'hA5, -1, 8'h00);
        @(negedge clk);
        checkIdle("a5 after");

        @(negedge clk);
        applyStimulus(8'h3C);
        checkFrame("3c", 8'h3C, -1, 8'h00);
        applyStimulus(8'hC3);
        checkFrame("c3 b2b", 8'hC3, -1, 8'h00);
        @(negedge clk);
        checkIdle("c3 after");

        @(negedge clk);
        applyStimulus(8'h00);
        checkFrame("00 ignore", 8'h00, 30, 8'hFF);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i % 7 == 0) checkIdle($sformatf("00 after %0d", i));
        end

        applyStimulus(8'h55);
        repeat (45) @(negedge clk);
        checkOutput("mid frame tx", 32'(tx), 32'd0);
        #2 rst = 1'b0;
        #1 checkIdle("async reset");
        @(negedge clk);
        checkIdle("reset held");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i % 6 == 5) checkIdle($sformatf("post reset %0d", i));
        end

        applyStimulus(8'h81);
        checkFrame("81", 8'h81, -1, 8'h00);
        @(negedge clk);

        @(negedge clk);
        applyStimulus(8'h07);
        checkFrame("07", 8'h07, -1, 8'h00);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(8'h03);
        checkFrame("03", 8'h03, -1, 8'h00);
        @(negedge clk);
        checkIdle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
